// File: rtl/card_picker.sv
// rtl/card_picker.sv - cursor-driven card selector that issues one handout strobe per confirm
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   turn_start            one-cycle request to begin a pick (IDLE only)
//   btn_left/right        synchronised levels; rising edge moves the cursor down/up
//   btn_confirm           synchronised level; rising edge commits the cursor card
//   used[8:0]             used-card flags fed back from the handout stage
//   cursor[8:0]           one-hot cursor for display, 0 outside SELECT or when no card is free
//   cardselect[8:0]       one-hot committed card, stable across ARM/FIRE/HOLD
//   handout_pulse         one-cycle commit strobe (used downstream as a clock)
//   busy                  high in every state except IDLE
//   no_cards              high in SELECT while every slot is used
module card_picker (
    input  logic       clk,
    input  logic       resetn,
    input  logic       turn_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    input  logic [8:0] used,
    output logic [8:0] cursor,
    output logic [8:0] cardselect,
    output logic       handout_pulse,
    output logic       busy,
    output logic       no_cards
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_FIRE,
        S_HOLD
    } state_t;

    localparam logic [3:0] IDX_NONE = 4'd15;

    state_t     state, state_nx;
    logic [3:0] idx, idx_nx;
    logic [8:0] sel_nx;
    logic       prev_left, prev_right, prev_confirm;
    logic       ev_left, ev_right, ev_confirm;
    logic       cur_free;

    function automatic logic [8:0] onehot(input logic [3:0] i);
        logic [8:0] r;
        r = '0;
        if (i <= 4'd8) r = 9'd1 << i;
        return r;
    endfunction

    function automatic logic [3:0] lowest_free(input logic [8:0] u);
        logic [3:0] r;
        r = IDX_NONE;
        for (int i = 8; i >= 0; i--) begin
            if (!u[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Nearest free slot in the given direction, modulo 9. Distances are
    // scanned far-to-near so the nearest hit is the one left standing.
    // The start slot itself is only reached at distance 9, which is never
    // scanned, so with no other free slot the cursor stays put.
    function automatic logic [3:0] seek(input logic [3:0] from, input logic [8:0] u,
                                        input logic up);
        logic [3:0] r;
        logic [4:0] s;
        r = from;
        for (int d = 8; d >= 1; d--) begin
            s = {1'b0, from} + (up ? 5'(d) : 5'(9 - d));
            if (s >= 5'd9) s = s - 5'd9;
            if (|(onehot(s[3:0]) & ~u)) r = s[3:0];
        end
        return r;
    endfunction

    assign ev_left    = btn_left    & ~prev_left;
    assign ev_right   = btn_right   & ~prev_right;
    assign ev_confirm = btn_confirm & ~prev_confirm;
    assign cur_free   = |(onehot(idx) & ~used);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        sel_nx   = cardselect;
        case (state)
            S_IDLE: begin
                if (turn_start) begin
                    state_nx = S_SELECT;
                    idx_nx   = lowest_free(used);
                end
            end
            S_SELECT: begin
                // A cursor that is invalid or sits on a now-used slot is
                // repaired before any button is honoured.
                if (!cur_free) begin
                    idx_nx = lowest_free(used);
                end else if (ev_confirm) begin
                    state_nx = S_ARM;
                    sel_nx   = onehot(idx);
                end else if (ev_right && !ev_left) begin
                    idx_nx = seek(idx, used, 1'b1);
                end else if (ev_left && !ev_right) begin
                    idx_nx = seek(idx, used, 1'b0);
                end
            end
            S_ARM:  state_nx = S_FIRE;
            S_FIRE: state_nx = S_HOLD;
            S_HOLD: begin
                state_nx = S_IDLE;
                sel_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                sel_nx   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so every output is a flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            idx           <= IDX_NONE;
            cardselect    <= '0;
            handout_pulse <= 1'b0;
            busy          <= 1'b0;
            no_cards      <= 1'b0;
            cursor        <= '0;
            prev_left     <= 1'b0;
            prev_right    <= 1'b0;
            prev_confirm  <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            cardselect    <= sel_nx;
            handout_pulse <= (state_nx == S_FIRE);
            busy          <= (state_nx != S_IDLE);
            no_cards      <= (state_nx == S_SELECT) && (used == 9'h1FF);
            cursor        <= (state_nx == S_SELECT) ? onehot(idx_nx) : 9'd0;
            prev_left     <= btn_left;
            prev_right    <= btn_right;
            prev_confirm  <= btn_confirm;
        end
    end

endmodule

// File: tb/tb_card_picker.sv
// tb/tb_card_picker.sv - scoreboard bench for card_picker
module tb_card_picker;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       turn_start = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_confirm = 1'b0;
    logic [8:0] used = '0;
    logic [8:0] cursor;
    logic [8:0] cardselect;
    logic       handout_pulse;
    logic       busy;
    logic       no_cards;

    card_picker dut (
        .clk(clk),
        .resetn(resetn),
        .turn_start(turn_start),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_confirm(btn_confirm),
        .used(used),
        .cursor(cursor),
        .cardselect(cardselect),
        .handout_pulse(handout_pulse),
        .busy(busy),
        .no_cards(no_cards)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] cursor;
        logic [8:0] cardselect;
        logic       pulse;
        logic       busy;
        logic       no_cards;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] commit_q[$];

    // Reference model: phase 0 idle, 1 picking, 2 committing (m_cnt edges left)
    int         m_phase = 0;
    int         m_cur = -1;
    int         m_cnt = 0;
    logic [8:0] m_sel = '0;
    logic       m_pl = 0, m_pr = 0, m_pc = 0;

    task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_lowest(input logic [8:0] u);
        for (int i = 0; i < 9; i++) if (!u[i]) return i;
        return -1;
    endfunction

    function automatic int m_next(input int cur, input int dir, input logic [8:0] u);
        for (int d = 1; d < 9; d++) begin
            int j;
            j = (cur + dir * d + 9) % 9;
            if (!u[j]) return j;
        end
        return cur;
    endfunction

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic m_edge();
        exp_t e;
        logic el, er, ec;
        if (!resetn) begin
            m_phase = 0; m_cur = -1; m_cnt = 0; m_sel = '0;
            m_pl = 0; m_pr = 0; m_pc = 0;
        end else begin
            el = btn_left && !m_pl;
            er = btn_right && !m_pr;
            ec = btn_confirm && !m_pc;
            case (m_phase)
                0: if (turn_start) begin
                    m_phase = 1;
                    m_cur = m_lowest(used);
                end
                1: begin
                    if (m_cur < 0 || used[m_cur]) begin
                        m_cur = m_lowest(used);
                    end else if (ec) begin
                        m_phase = 2;
                        m_cnt = 3;
                        m_sel = 9'd1 << m_cur;
                        commit_q.push_back(m_sel);
                    end else if (er && !el) begin
                        m_cur = m_next(m_cur, 1, used);
                    end else if (el && !er) begin
                        m_cur = m_next(m_cur, -1, used);
                    end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 0;
                        m_sel = '0;
                    end
                end
            endcase
            m_pl = btn_left; m_pr = btn_right; m_pc = btn_confirm;
        end
        e.cursor     = (m_phase == 1 && m_cur >= 0) ? (9'd1 << m_cur) : 9'd0;
        e.cardselect = m_sel;
        e.pulse      = (m_phase == 2 && m_cnt == 2);
        e.busy       = (m_phase != 0);
        e.no_cards   = (m_phase == 1 && used == 9'h1FF);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rn, input logic t, input logic l, input logic r,
                        input logic c, input logic [8:0] u);
        @(negedge clk);
        resetn = rn; turn_start = t; btn_left = l; btn_right = r; btn_confirm = c; used = u;
        m_edge();
        @(posedge clk);
        #2;
    endtask

    // Per-cycle monitor and commit monitor
    always @(posedge clk) begin
        exp_t e;
        logic [8:0] c;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("cursor", cursor, e.cursor);
            cmp("cardselect", cardselect, e.cardselect);
            cmp("handout_pulse", 9'(handout_pulse), 9'(e.pulse));
            cmp("busy", 9'(busy), 9'(e.busy));
            cmp("no_cards", 9'(no_cards), 9'(e.no_cards));
        end
        if (handout_pulse) begin
            if (commit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse got pulse with card %h expected no pulse at %0t",
                         cardselect, $time);
            end else begin
                c = commit_q.pop_front();
                cmp("pulse_card", cardselect, c);
            end
        end
    end

    task automatic idle(input int n, input logic [8:0] u);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, u);
    endtask

    initial begin
        logic t, l, r, c;
        logic [8:0] u;

        // Reset state
        step(0, 0, 0, 0, 0, 9'h000);
        step(0, 0, 0, 0, 0, 9'h000);
        cmp("reset_busy", 9'(busy), 9'h0);
        cmp("reset_cardselect", cardselect, 9'h000);

        // Basic pick
        idle(1, 9'h000);
        step(1, 1, 0, 0, 0, 9'h000);
        cmp("basic_cursor", cursor, 9'h001);
        step(1, 0, 0, 0, 1, 9'h000);
        cmp("basic_cardselect", cardselect, 9'h001);
        step(1, 0, 0, 0, 0, 9'h000);
        cmp("basic_pulse", 9'(handout_pulse), 9'h1);
        step(1, 0, 0, 0, 0, 9'h000);
        cmp("basic_pulse_low", 9'(handout_pulse), 9'h0);
        step(1, 0, 0, 0, 0, 9'h000);
        cmp("basic_busy_done", 9'(busy), 9'h0);

        // Skip and wrap with slots 4..8 used
        step(1, 1, 0, 0, 0, 9'h1F0);
        step(1, 0, 1, 0, 0, 9'h1F0);
        cmp("wrap_down_to_3", cursor, 9'h008);
        step(1, 0, 0, 0, 0, 9'h1F0);
        step(1, 0, 0, 1, 0, 9'h1F0);
        cmp("wrap_up_to_0", cursor, 9'h001);
        step(1, 0, 0, 0, 0, 9'h1F0);
        step(1, 0, 1, 0, 0, 9'h1F0);
        cmp("left_to_3", cursor, 9'h008);
        step(1, 0, 0, 0, 0, 9'h1F0);
        step(1, 0, 1, 0, 0, 9'h1F0);
        cmp("left_to_2", cursor, 9'h004);
        step(1, 0, 0, 0, 0, 9'h1F0);
        step(1, 0, 1, 0, 0, 9'h1F0);
        cmp("left_to_1", cursor, 9'h002);
        step(1, 0, 0, 0, 1, 9'h1F0);
        idle(4, 9'h1F2);

        // All used: confirm ignored, then a slot frees up
        step(1, 1, 0, 0, 0, 9'h1FF);
        cmp("all_used_no_cards", 9'(no_cards), 9'h1);
        cmp("all_used_cursor", cursor, 9'h000);
        step(1, 0, 0, 0, 1, 9'h1FF);
        cmp("all_used_no_commit", cardselect, 9'h000);
        step(1, 0, 0, 0, 0, 9'h1FF);
        step(1, 0, 0, 0, 0, 9'h1FE);
        cmp("freed_cursor", cursor, 9'h001);
        step(1, 0, 0, 0, 1, 9'h1FE);
        idle(4, 9'h1FF);

        // Simultaneous events and held button
        step(1, 1, 0, 0, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        step(1, 0, 0, 0, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        cmp("held_moves_once", cursor, 9'h004);
        step(1, 0, 0, 0, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        step(1, 0, 0, 0, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        step(1, 0, 0, 0, 0, 9'h000);
        step(1, 0, 1, 1, 0, 9'h000);
        cmp("left_right_cancel", cursor, 9'h010);
        step(1, 0, 0, 0, 0, 9'h000);
        step(1, 0, 0, 1, 1, 9'h000);
        cmp("confirm_beats_right", cardselect, 9'h010);
        // Interference during commit
        step(1, 1, 1, 0, 0, 9'h000);
        step(1, 1, 0, 1, 1, 9'h000);
        step(1, 1, 1, 0, 0, 9'h000);
        cmp("interfere_idle", 9'(busy), 9'h0);
        idle(2, 9'h010);

        // Reset mid-commit
        step(1, 1, 0, 0, 0, 9'h000);
        step(1, 0, 0, 0, 1, 9'h000);
        step(1, 0, 0, 0, 0, 9'h000);
        @(negedge clk);
        resetn = 1'b0; btn_confirm = 1'b0;
        #1;
        cmp("async_pulse_drop", 9'(handout_pulse), 9'h0);
        cmp("async_card_drop", cardselect, 9'h000);
        m_edge();
        @(posedge clk);
        #2;
        step(1, 0, 0, 0, 0, 9'h000);
        step(1, 1, 0, 0, 0, 9'h000);
        step(1, 0, 0, 1, 0, 9'h000);
        step(1, 0, 0, 0, 1, 9'h000);
        cmp("post_reset_pick", cardselect, 9'h002);
        idle(4, 9'h002);

        // Randomized run
        t = 0; l = 0; r = 0; c = 0; u = 9'h000;
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) l = ~l;
            if ($urandom_range(0, 3) == 0) r = ~r;
            if ($urandom_range(0, 9) == 0) c = ~c;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0: u = 9'($urandom);
                    1: u = 9'h1FF;
                    2: u = 9'($urandom) | 9'($urandom);
                    default: u = 9'h1FF & ~(9'd1 << $urandom_range(0, 8));
                endcase
            end
            step(1, t, l, r, c, u);
        end
        idle(6, u);

        checks++;
        if (commit_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulse got %0d unissued commits expected 0", commit_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
